// File: rtl/uart_tx_dma_if.sv
// Bus bundle for uart_tx_dma: 32-bit memory read port plus UART register port.
// Both ports use a valid/ready handshake, master drives valid and address/data.
interface uart_tx_dma_if;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_rdata;

    logic        u_valid;
    logic        u_ready;
    logic [11:0] u_addr;
    logic [31:0] u_wdata;
    logic [3:0]  u_wstrb;
    logic [31:0] u_rdata;

    modport master (
        output m_valid, m_addr,
        input  m_ready, m_rdata,
        output u_valid, u_addr, u_wdata, u_wstrb,
        input  u_ready, u_rdata
    );

    modport slave (
        input  m_valid, m_addr,
        output m_ready, m_rdata,
        input  u_valid, u_addr, u_wdata, u_wstrb,
        output u_ready, u_rdata
    );
endinterface

// File: rtl/uart_tx_dma.sv
// TX DMA sequencer: reads bytes from memory a word at a time and writes them to
// the UART DR, polling SR.tf_full before every write.
//
// state | meaning
// IDLE  | no transfer; start launches one
// FETCH | memory word read of the word holding ptr
// POLL  | SR read, checks tf_full
// WAIT  | tf_full was set; idle POLL_GAP cycles before polling again
// WRITE | DR write of byte lane ptr[1:0] from wbuf
module uart_tx_dma #(
    parameter int          LW       = 16,
    parameter int          POLL_GAP = 8,
    parameter logic [11:0] ADDR_SR  = 12'h04,
    parameter logic [11:0] ADDR_DR  = 12'h08
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [31:0]   src_addr,
    input  logic [LW-1:0] length,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [LW-1:0] remain,
    uart_tx_dma_if.master bus
);

    typedef enum logic [2:0] {IDLE, FETCH, POLL, WAIT, WRITE} state_t;

    localparam logic [7:0] GAP = 8'(POLL_GAP);

    state_t        state_q, state_d;
    logic [31:0]   ptr_q, ptr_d;
    logic [LW-1:0] remain_q, remain_d;
    logic [31:0]   wbuf_q, wbuf_d;
    logic [7:0]    gap_q, gap_d;
    logic          abort_pend_q, abort_pend_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          aborted_q, aborted_d;
    logic          m_valid_q, m_valid_d;
    logic [31:0]   m_addr_q, m_addr_d;
    logic          u_valid_q, u_valid_d;
    logic [11:0]   u_addr_q, u_addr_d;
    logic [31:0]   u_wdata_q, u_wdata_d;
    logic [3:0]    u_wstrb_q, u_wstrb_d;

    logic          abort_now;
    logic          to_abort;
    logic          to_done;
    logic [31:0]   ptr_inc;
    logic [7:0]    lane;
    logic          unused_rdata;

    assign unused_rdata = ^{bus.u_rdata[31:3], bus.u_rdata[1:0]};

    always_comb begin
        unique case (ptr_q[1:0])
            2'd0:    lane = wbuf_q[7:0];
            2'd1:    lane = wbuf_q[15:8];
            2'd2:    lane = wbuf_q[23:16];
            default: lane = wbuf_q[31:24];
        endcase
    end

    // Every bus state raises valid on its first cycle and leaves on ready, so
    // valid always drops for at least one cycle between transactions.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        remain_d     = remain_q;
        wbuf_d       = wbuf_q;
        gap_d        = gap_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        m_valid_d    = m_valid_q;
        m_addr_d     = m_addr_q;
        u_valid_d    = u_valid_q;
        u_addr_d     = u_addr_q;
        u_wdata_d    = u_wdata_q;
        u_wstrb_d    = u_wstrb_q;
        abort_pend_d = abort_pend_q | (abort && (state_q != IDLE));
        abort_now    = abort | abort_pend_q;
        ptr_inc      = ptr_q + 32'd1;
        to_abort     = 1'b0;
        to_done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                abort_pend_d = 1'b0;
                if (start) begin
                    if (length != '0) begin
                        ptr_d    = src_addr;
                        remain_d = length;
                        busy_d   = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        remain_d = '0;
                        done_d   = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (!m_valid_q) begin
                    if (abort_now) begin
                        to_abort = 1'b1;
                    end else begin
                        m_valid_d = 1'b1;
                        m_addr_d  = {ptr_q[31:2], 2'b00};
                    end
                end else if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    wbuf_d    = bus.m_rdata;
                    if (abort_now) to_abort = 1'b1;
                    else           state_d  = POLL;
                end
            end
            POLL: begin
                if (!u_valid_q) begin
                    if (abort_now) begin
                        to_abort = 1'b1;
                    end else begin
                        u_valid_d = 1'b1;
                        u_addr_d  = ADDR_SR;
                        u_wstrb_d = 4'b0000;
                        u_wdata_d = '0;
                    end
                end else if (bus.u_ready) begin
                    u_valid_d = 1'b0;
                    if (abort_now) begin
                        to_abort = 1'b1;
                    end else if (bus.u_rdata[2]) begin
                        if (GAP != 8'd0) begin
                            state_d = WAIT;
                            gap_d   = GAP - 8'd1;
                        end
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WAIT: begin
                if (abort_now)          to_abort = 1'b1;
                else if (gap_q == 8'd0) state_d  = POLL;
                else                    gap_d    = gap_q - 8'd1;
            end
            WRITE: begin
                if (!u_valid_q) begin
                    if (abort_now) begin
                        to_abort = 1'b1;
                    end else begin
                        u_valid_d = 1'b1;
                        u_addr_d  = ADDR_DR;
                        u_wstrb_d = 4'b0001;
                        u_wdata_d = {24'b0, lane};
                    end
                end else if (bus.u_ready) begin
                    u_valid_d = 1'b0;
                    ptr_d     = ptr_inc;
                    if (remain_q != '0) remain_d = remain_q - 1'b1;
                    if (remain_q <= 1)              to_done  = 1'b1;
                    else if (abort_now)             to_abort = 1'b1;
                    else if (ptr_inc[1:0] == 2'b00) state_d  = FETCH;
                    else                            state_d  = POLL;
                end
            end
            default: state_d = IDLE;
        endcase

        if (to_done) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            abort_pend_d = 1'b0;
        end else if (to_abort) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            aborted_d    = 1'b1;
            abort_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            remain_q     <= '0;
            wbuf_q       <= '0;
            gap_q        <= '0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_addr_q     <= '0;
            u_valid_q    <= 1'b0;
            u_addr_q     <= '0;
            u_wdata_q    <= '0;
            u_wstrb_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            remain_q     <= remain_d;
            wbuf_q       <= wbuf_d;
            gap_q        <= gap_d;
            abort_pend_q <= abort_pend_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            m_valid_q    <= m_valid_d;
            m_addr_q     <= m_addr_d;
            u_valid_q    <= u_valid_d;
            u_addr_q     <= u_addr_d;
            u_wdata_q    <= u_wdata_d;
            u_wstrb_q    <= u_wstrb_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign remain      = remain_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.u_valid = u_valid_q;
    assign bus.u_addr  = u_addr_q;
    assign bus.u_wdata = u_wdata_q;
    assign bus.u_wstrb = u_wstrb_q;

endmodule

// File: tb/tb_uart_tx_dma.sv
// Directed bench for uart_tx_dma with a memory responder and a UART register
// responder that tracks tf_full and flags handshake violations.
module tb_uart_tx_dma;
    localparam int LW       = 16;
    localparam int POLL_GAP = 8;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic [31:0]   src_addr = '0;
    logic [LW-1:0] length   = '0;
    logic          busy, done, aborted;
    logic [LW-1:0] remain;

    uart_tx_dma_if bus();

    uart_tx_dma #(.LW(LW), .POLL_GAP(POLL_GAP), .ADDR_SR(12'h04), .ADDR_DR(12'h08)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .src_addr(src_addr), .length(length), .busy(busy), .done(done),
        .aborted(aborted), .remain(remain), .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] mr_log[$];
    logic [7:0]  dr_log[$];
    int          sr_cyc[$];
    int          m_viol = 0, u_viol = 0, wr_full = 0, bad_acc = 0;
    int          cyc = 0, done_cnt = 0, abrt_cnt = 0, valid_cyc = 0;
    int          full_cnt = 0, u_lat = 0;
    bit          m_ack_prev = 0, u_ack_prev = 0, last_full = 0;
    int          u_wait = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h44332211;
        if (a == 32'h104) return 32'h88776655;
        return {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]};
    endfunction

    initial begin
        bus.m_ready = 1'b0;
        bus.m_rdata = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            if (m_ack_prev) begin
                if (bus.m_valid) m_viol++;
                bus.m_ready = 1'b0;
                bus.m_rdata = 32'hDEADBEEF;
                m_ack_prev  = 0;
            end else if (bus.m_valid) begin
                bus.m_ready = 1'b1;
                bus.m_rdata = mem_word(bus.m_addr);
                mr_log.push_back(bus.m_addr);
                m_ack_prev  = 1;
            end else begin
                bus.m_ready = 1'b0;
            end
        end
    end

    // UART side: SR reads return tf_full while full_cnt > 0; idle rdata has bit2 set.
    initial begin
        bus.u_ready = 1'b0;
        bus.u_rdata = 32'hFFFFFFFF;
        forever begin
            @(negedge clk);
            cyc++;
            if (done)    done_cnt++;
            if (aborted) abrt_cnt++;
            if (bus.m_valid || bus.u_valid) valid_cyc++;
            if (u_ack_prev) begin
                if (bus.u_valid) u_viol++;
                bus.u_ready = 1'b0;
                bus.u_rdata = 32'hFFFFFFFF;
                u_ack_prev  = 0;
                u_wait      = 0;
            end else if (bus.u_valid) begin
                if (u_wait >= u_lat) begin
                    bus.u_ready = 1'b1;
                    u_ack_prev  = 1;
                    if (bus.u_addr == 12'h04 && bus.u_wstrb == 4'b0000) begin
                        sr_cyc.push_back(cyc);
                        last_full   = (full_cnt > 0);
                        bus.u_rdata = last_full ? 32'h4 : 32'h0;
                        if (full_cnt > 0) full_cnt--;
                    end else if (bus.u_addr == 12'h08 && bus.u_wstrb == 4'b0001) begin
                        if (last_full) wr_full++;
                        dr_log.push_back(bus.u_wdata[7:0]);
                    end else begin
                        bad_acc++;
                    end
                end else begin
                    u_wait++;
                end
            end else begin
                bus.u_ready = 1'b0;
                u_wait      = 0;
            end
        end
    end

    task automatic clear_logs();
        mr_log.delete();
        dr_log.delete();
        sr_cyc.delete();
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [LW-1:0] n);
        @(negedge clk);
        src_addr = a;
        length   = n;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_end(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done || aborted) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_dr_write(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.u_valid && bus.u_wstrb == 4'b0001) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++; if ({busy, done, aborted} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {busy, done, aborted}); end
        tests++; if (remain !== 16'd0) begin fails++; $display("FAIL reset_remain: got %0d want 0", remain); end
        tests++; if ({bus.m_valid, bus.m_addr} !== 33'd0) begin fails++; $display("FAIL reset_m: got %b/%h want 0/0", bus.m_valid, bus.m_addr); end
        tests++; if ({bus.u_valid, bus.u_addr, bus.u_wdata, bus.u_wstrb} !== 49'd0) begin fails++; $display("FAIL reset_u: got %b/%h/%h/%b want zeros", bus.u_valid, bus.u_addr, bus.u_wdata, bus.u_wstrb); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if ({busy, bus.m_valid, bus.u_valid} !== 3'b000) begin fails++; $display("FAIL post_reset_idle: got %b want 000", {busy, bus.m_valid, bus.u_valid}); end
    endtask

    task automatic test_aligned();
        int d0;
        bit ok;
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_logs();
        u_lat = 0;
        d0 = done_cnt;
        pulse_start(32'h100, 16'd4);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL aligned_busy: got %b want 1", busy); end
        wait_end(500, ok);
        tests++; if (!ok) begin fails++; $display("FAIL aligned_timeout: got no done want done"); end
        tests++; if (mr_log.size() != 1 || mr_log[0] !== 32'h100) begin fails++; $display("FAIL aligned_fetch: got %0d reads want 1 read of 100", mr_log.size()); end
        tests++; if (dr_log.size() != 4) begin fails++; $display("FAIL aligned_dr_count: got %0d want 4", dr_log.size()); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (((i < dr_log.size()) ? dr_log[i] : 8'hxx) !== exp_b[i]) begin fails++; $display("FAIL aligned_dr%0d: got %h want %h", i, (i < dr_log.size()) ? dr_log[i] : 8'hxx, exp_b[i]); end
        end
        tests++; if (sr_cyc.size() != 4) begin fails++; $display("FAIL aligned_sr_count: got %0d want 4", sr_cyc.size()); end
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL aligned_done_pulse: got %0d cycles want 1", done_cnt - d0); end
        tests++; if ({busy, remain} !== 17'd0) begin fails++; $display("FAIL aligned_end: got busy %b remain %0d want 0/0", busy, remain); end
    endtask

    task automatic test_unaligned();
        bit ok;
        logic [7:0] exp_b [3];
        exp_b = '{8'h44, 8'h55, 8'h66};
        clear_logs();
        pulse_start(32'h103, 16'd3);
        wait_end(500, ok);
        tests++; if (!ok) begin fails++; $display("FAIL unaligned_timeout: got no done want done"); end
        tests++; if (mr_log.size() != 2) begin fails++; $display("FAIL unaligned_reads: got %0d want 2", mr_log.size()); end
        tests++; if (mr_log.size() == 2 && (mr_log[0] !== 32'h100 || mr_log[1] !== 32'h104)) begin fails++; $display("FAIL unaligned_addrs: got %h,%h want 100,104", mr_log[0], mr_log[1]); end
        tests++; if (dr_log.size() != 3) begin fails++; $display("FAIL unaligned_dr_count: got %0d want 3", dr_log.size()); end
        for (int i = 0; i < 3; i++) begin
            tests++; if (((i < dr_log.size()) ? dr_log[i] : 8'hxx) !== exp_b[i]) begin fails++; $display("FAIL unaligned_dr%0d: got %h want %h", i, (i < dr_log.size()) ? dr_log[i] : 8'hxx, exp_b[i]); end
        end
    endtask

    task automatic test_tf_full();
        bit ok;
        clear_logs();
        full_cnt = 3;
        pulse_start(32'h100, 16'd1);
        wait_end(800, ok);
        tests++; if (!ok) begin fails++; $display("FAIL full_timeout: got no done want done"); end
        tests++; if (sr_cyc.size() != 4) begin fails++; $display("FAIL full_sr_reads: got %0d want 4", sr_cyc.size()); end
        for (int i = 1; i < 4; i++) begin
            tests++; if (i < sr_cyc.size() && sr_cyc[i] - sr_cyc[i-1] - 1 < POLL_GAP) begin fails++; $display("FAIL full_gap%0d: got %0d idle want >= %0d", i, sr_cyc[i] - sr_cyc[i-1] - 1, POLL_GAP); end
        end
        tests++; if (wr_full != 0) begin fails++; $display("FAIL full_write_while_full: got %0d want 0", wr_full); end
        tests++; if (dr_log.size() != 1 || dr_log[0] !== 8'h11) begin fails++; $display("FAIL full_dr: got %0d writes want 1 of 11", dr_log.size()); end
    endtask

    task automatic test_zero_len();
        int v0, d0;
        clear_logs();
        v0 = valid_cyc;
        d0 = done_cnt;
        @(negedge clk);
        src_addr = 32'h300;
        length   = '0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done_next: got %b want 1", done); end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL zero_done_width: got %b want 0", done); end
        repeat (10) @(negedge clk);
        tests++; if (valid_cyc != v0) begin fails++; $display("FAIL zero_no_bus: got %0d valid cycles want 0", valid_cyc - v0); end
        tests++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin fails++; $display("FAIL zero_pulse: got %0d done cycles busy %b want 1/0", done_cnt - d0, busy); end
    endtask

    task automatic test_abort();
        int d0, a0, v0;
        bit ok;
        clear_logs();
        u_lat = 3;
        d0 = done_cnt;
        a0 = abrt_cnt;
        pulse_start(32'h200, 16'd10);
        wait_dr_write(ok);
        tests++; if (!ok) begin fails++; $display("FAIL abort_no_write: got none want DR write"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_end(200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL abort_timeout: got no aborted want aborted"); end
        tests++; if (dr_log.size() != 1 || dr_log[0] !== 8'h00) begin fails++; $display("FAIL abort_dr: got %0d writes want 1 of 00", dr_log.size()); end
        tests++; if (remain !== 16'd9) begin fails++; $display("FAIL abort_remain: got %0d want 9", remain); end
        tests++; if (abrt_cnt - a0 != 1 || done_cnt != d0) begin fails++; $display("FAIL abort_pulses: got aborted %0d done %0d want 1/0", abrt_cnt - a0, done_cnt - d0); end
        v0 = valid_cyc;
        repeat (20) @(negedge clk);
        tests++; if (valid_cyc != v0 || busy !== 1'b0) begin fails++; $display("FAIL abort_quiet: got %0d valid cycles busy %b want 0/0", valid_cyc - v0, busy); end
    endtask

    task automatic test_handshake();
        tests++; if (m_viol != 0) begin fails++; $display("FAIL hs_mem: got %0d late-valid cycles want 0", m_viol); end
        tests++; if (u_viol != 0) begin fails++; $display("FAIL hs_uart: got %0d late-valid cycles want 0", u_viol); end
        tests++; if (bad_acc != 0) begin fails++; $display("FAIL hs_bad_access: got %0d want 0", bad_acc); end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        clear_logs();
        u_lat = 5;
        pulse_start(32'h100, 16'd4);
        wait_dr_write(ok);
        tests++; if (!ok) begin fails++; $display("FAIL rstmid_no_write: got none want DR write"); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({busy, done, aborted, remain} !== 19'd0) begin fails++; $display("FAIL rstmid_status: got %b/%0d want 0/0", {busy, done, aborted}, remain); end
        tests++; if ({bus.m_valid, bus.m_addr} !== 33'd0) begin fails++; $display("FAIL rstmid_m: got %b/%h want 0/0", bus.m_valid, bus.m_addr); end
        tests++; if ({bus.u_valid, bus.u_addr, bus.u_wdata, bus.u_wstrb} !== 49'd0) begin fails++; $display("FAIL rstmid_u: got %b/%h/%h/%b want zeros", bus.u_valid, bus.u_addr, bus.u_wdata, bus.u_wstrb); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        tests++; if (dr_log.size() != 0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_after: got %0d writes busy %b want 0/0", dr_log.size(), busy); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_unaligned();
        test_tf_full();
        test_zero_len();
        test_abort();
        test_handshake();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish by 500000");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx_dma.md
Name: uart_tx_dma

Overview:
- Transmit DMA sequencer that drains a byte buffer from system memory into the UART TX FIFO without CPU involvement.
- Acts as a bus master on two ports: a 32-bit word-read port to memory, and the UART register port (CR/SR/DR/CKDIV map, valid/ready protocol).
- Before every DR write it polls SR.tf_full, because DR writes are silently dropped while the TX FIFO is full.
- Sits between the CPU config registers and the UART register block, muxed onto the UART bus upstream.

Parameters:
- LW, 16, width of the length/remaining counters.
- POLL_GAP, 8, idle cycles between consecutive SR polls while tf_full=1 (range 0..255).
- ADDR_SR, 12'h04, UART status register offset.
- ADDR_DR, 12'h08, UART data register offset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse; launches a transfer when idle
- abort  in  1  one-cycle pulse; stops the transfer after any outstanding bus cycle completes
- src_addr  in  32  byte start address; unaligned allowed
- length  in  LW  byte count
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at normal completion
- aborted  out  1  one-cycle pulse at abort completion
- remain  out  LW  bytes not yet written to DR
- m_valid  out  1  memory read request
- m_ready  in  1  memory read acknowledge; m_rdata valid in this cycle
- m_addr  out  32  word address, bits[1:0]=0
- m_rdata  in  32  read data, little-endian byte lanes
- u_valid  out  1  UART register request
- u_ready  in  1  one-cycle acknowledge; u_rdata valid in this cycle
- u_addr  out  12  UART register offset
- u_wdata  out  32  write data
- u_wstrb  out  4  4'b0001 = write, 4'b0000 = read
- u_rdata  in  32  UART read data

Behaviour:
- Reset: busy=0, done=0, aborted=0, remain=0, m_valid=0, m_addr=0, u_valid=0, u_addr=0, u_wdata=0, u_wstrb=0; state=IDLE.

Handshake rules (both master ports):
- valid and address/data are registered and held stable until ready is sampled high.
- valid drops in the cycle after ready. The UART block re-acks a held valid two cycles later, so valid must never stay high past ready.

State machine:
- IDLE:
  - start & length!=0: latch ptr=src_addr, remain=length; busy=1; go to FETCH.
  - start & length==0: done=1 in the next cycle; no bus traffic.
  - start while busy is ignored.
- FETCH: m_valid=1, m_addr={ptr[31:2],2'b00}. On m_ready, latch m_rdata into wbuf and go to POLL.
- POLL: u_valid=1, u_addr=ADDR_SR, u_wstrb=0. On u_ready, sample u_rdata[2] (tf_full):
  - 0: go to WRITE.
  - 1: go to WAIT.
- WAIT: count POLL_GAP cycles, then go to POLL. POLL_GAP=0 goes to POLL immediately.
- WRITE: u_valid=1, u_addr=ADDR_DR, u_wstrb=4'b0001, u_wdata={24'b0, wbuf byte lane ptr[1:0]}. On u_ready:
  - ptr += 1; remain -= 1.
  - remain becomes 0: go to IDLE, busy=0, done=1 for one cycle.
  - else if the new ptr[1:0]==0: go to FETCH (word boundary).
  - else: go to POLL, reusing wbuf.
- Each word is fetched exactly once. An unaligned start fetches the containing word and uses lanes from ptr[1:0] upward.
- ptr wraps modulo 2^32. remain never underflows.
- abort:
  - Sets a pending flag.
  - If a bus cycle is in flight (valid=1), that cycle completes; the completed DR write counts in remain.
  - Then go to IDLE, busy=0, aborted=1 for one cycle, done=0.
  - Abort in WAIT takes effect next cycle.
  - Abort in IDLE: no effect.
  - abort and start in the same IDLE cycle: start wins and abort is ignored.
- SR.error/txbusy are ignored. Completion means "last byte accepted by DR", not "shifted out".
- Reset mid-transfer: all outputs return to reset values immediately, including u_valid. The UART block's own reset is assumed coincident.

Test Plan:
- src_addr=0x100, length=4, mem word=0x44332211, tf_full=0 → one FETCH of 0x100, then four POLL/WRITE pairs with u_wdata 0x11,0x22,0x33,0x44; done pulse; remain=0.
- src_addr=0x103, length=3 → fetches 0x100 (lane 3) and 0x104 (lanes 0,1); exactly 2 memory reads and 3 DR writes in address order.
- tf_full=1 on the first 3 SR reads, POLL_GAP=8 → exactly 4 SR reads spaced ≥8 idle cycles apart; the DR write occurs only after tf_full=0; no DR write is issued while full.
- length=0 start → done pulse 1 cycle later; m_valid and u_valid stay 0.
- abort asserted while a DR write is awaiting u_ready, length=10 → that write completes; remain=9 after it; aborted pulse; no done; no further bus cycles.
- Any u_valid cycle → u_valid deasserts the cycle after u_ready, and no double-ack is observed. Also check rst_n asserted mid-WRITE: all outputs go to zero asynchronously.
